// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline controller.
// Optional multiply support is selected with the PIPE_CTRL_MULT_EN macro.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_NOP   = 6'b000000;
  localparam logic [5:0] FN_ADD   = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101011;
  localparam logic [5:0] FN_MULT  = 6'b011000;

  localparam logic [1:0] PC_SEQ   = 2'd0;
  localparam logic [1:0] PC_BR    = 2'd1;
  localparam logic [1:0] PC_JMP   = 2'd2;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_MUL = 3'd5
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;
    logic    reg_write;
    logic    mem_write;
    logic    mem_read;
    logic    alu_sel;
    logic    mem_to_reg;
    alu_op_e alu_op;
  } ctrl_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MUL_WAIT = 2'd2
  } state_e;

  // Bundle for a register-register ALU operation writing rd.
  function automatic ctrl_t rtype_ctrl(input alu_op_e op);
    ctrl_t c;
    c           = '0;
    c.reg_dst   = 1'b1;
    c.reg_write = 1'b1;
    c.alu_op    = op;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Purely combinational instruction decode: control bundle, destination
// register and an illegal flag. mult decodes only with PIPE_CTRL_MULT_EN.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  input  logic [4:0] rt_i,
  input  logic [4:0] rd_i,
  output ctrl_t      ctrl_o,
  output logic [4:0] dest_o,
  output logic       illegal_o
);

  // Opcode/func table; anything unrecognised yields a zero bundle plus illegal.
  always_comb begin
    ctrl_o    = '0;
    dest_o    = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_LW: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.alu_sel    = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.alu_op     = ALU_ADD;
        dest_o            = rt_i;
      end
      OP_SW: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_sel   = 1'b1;
        ctrl_o.alu_op    = ALU_ADD;
      end
      OP_BEQ, OP_BNE: ctrl_o.alu_op = ALU_SUB;
      OP_J: ;
      OP_RTYPE: begin
        case (func_i)
          FN_NOP: ;
          FN_ADD: begin ctrl_o = rtype_ctrl(ALU_ADD); dest_o = rd_i; end
          FN_SUB: begin ctrl_o = rtype_ctrl(ALU_SUB); dest_o = rd_i; end
          FN_AND: begin ctrl_o = rtype_ctrl(ALU_AND); dest_o = rd_i; end
          FN_OR:  begin ctrl_o = rtype_ctrl(ALU_OR);  dest_o = rd_i; end
          FN_SLT: begin ctrl_o = rtype_ctrl(ALU_SLT); dest_o = rd_i; end
`ifdef PIPE_CTRL_MULT_EN
          FN_MULT: begin ctrl_o = rtype_ctrl(ALU_MUL); dest_o = rd_i; end
`endif
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: ID/EX bundle register, load-use and multiply stalls,
// branch/jump PC select. Macro PIPE_CTRL_MULT_EN builds the multiply wait.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] instr_i,
  input  logic            instr_valid_i,
  input  logic            equal_i,
  output logic [1:0]      pc_src_o,
  output logic            if_flush_o,
  output logic            stall_o,
  output logic [8:0]      ex_ctrl_o,
  output logic [4:0]      ex_dest_o,
  output logic            mul_busy_o,
  output logic            illegal_o
);

  logic [5:0] op;
  logic [4:0] rs, rt;
  logic       uses_rt, lu_hazard, mul_wait;
  ctrl_t      dec_ctrl;
  logic [4:0] dec_dest;
  logic       dec_illegal;

  state_e     state_q, state_d;
  ctrl_t      ex_ctrl_q, ex_ctrl_d;
  logic [4:0] ex_dest_q, ex_dest_d;
  logic       illegal_q, illegal_d;

  logic       unused_shamt;
  assign unused_shamt = ^instr_i[10:6];

  assign op      = instr_i[31:26];
  assign rs      = instr_i[25:21];
  assign rt      = instr_i[20:16];
  assign uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);

  pipe_ctrl_decode u_dec (
    .op_i      (op),
    .func_i    (instr_i[5:0]),
    .rt_i      (rt),
    .rd_i      (instr_i[15:11]),
    .ctrl_o    (dec_ctrl),
    .dest_o    (dec_dest),
    .illegal_o (dec_illegal)
  );

  // A load in EX whose target feeds the instruction in ID.
  assign lu_hazard = instr_valid_i && ex_ctrl_q.mem_read && (ex_dest_q != 5'd0) &&
                     ((ex_dest_q == rs) || (uses_rt && (ex_dest_q == rt)));

`ifdef PIPE_CTRL_MULT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign mul_wait   = (state_q == MUL_WAIT);
  assign mul_busy_o = mul_wait;
`else
  assign mul_wait   = 1'b0;
  assign mul_busy_o = 1'b0;
`endif

  // Stall/redirect resolution, next bundle and next FSM state.
  always_comb begin
    state_d    = state_q;
    ex_ctrl_d  = '0;
    ex_dest_d  = '0;
    illegal_d  = 1'b0;
    pc_src_o   = PC_SEQ;
    if_flush_o = 1'b0;
    stall_o    = mul_wait || lu_hazard;
`ifdef PIPE_CTRL_MULT_EN
    cnt_d      = cnt_q;
`endif
    // Redirects and issue only happen on a non-stalled valid cycle, so a
    // stalled branch resolves when it is re-presented.
    if (instr_valid_i && !stall_o) begin
      if (op == OP_J) begin
        pc_src_o   = PC_JMP;
        if_flush_o = 1'b1;
      end else if ((op == OP_BEQ && equal_i) || (op == OP_BNE && !equal_i)) begin
        pc_src_o   = PC_BR;
        if_flush_o = 1'b1;
      end
      if (dec_illegal) begin
        illegal_d = 1'b1;
      end else begin
        ex_ctrl_d = dec_ctrl;
        ex_dest_d = dec_dest;
      end
    end
    case (state_q)
      RUN:      if (lu_hazard) state_d = LU_STALL;
      LU_STALL: state_d = RUN;
`ifdef PIPE_CTRL_MULT_EN
      MUL_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = RUN;
      end
`endif
      default:  state_d = RUN;
    endcase
`ifdef PIPE_CTRL_MULT_EN
    // A mult issuing (even the one re-presented after a load-use stall)
    // starts the wait; ALU_MUL only appears in an issued bundle.
    if (ex_ctrl_d.alu_op == ALU_MUL) begin
      state_d = MUL_WAIT;
      cnt_d   = CNT_W'(MUL_LAT - 1);
    end
`endif
  end

  // State and ID/EX registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      ex_ctrl_q <= '0;
      ex_dest_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ex_ctrl_q <= ex_ctrl_d;
      ex_dest_q <= ex_dest_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef PIPE_CTRL_MULT_EN
  // Multiply wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign ex_ctrl_o = ex_ctrl_q;
  assign ex_dest_o = ex_dest_q;
  assign illegal_o = illegal_q;

endmodule
